// File: rtl/serial_alu_seq.sv
// serial_alu_seq -- bit-serial sequencer for a combinational 1-bit ALU slice.
//
// Accepts a WIDTH-bit operand pair plus a 2-bit opcode and feeds the external
// slice one bit per clock, LSB first. The slice carry-out is registered and
// returned as the next bit's carry-in. Slice F outputs are shifted in from the
// MSB end so the result is aligned once all WIDTH bits have been processed.
//
// Optional feature: define SERIAL_ALU_ZERO_FLAG_EN to add the `zero` output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a, b     request (sampled in IDLE only), opcode, operands
//   busy, done          RUN-state decode, one-cycle DONE pulse
//   result, cout        assembled result and final ADD carry (held until next accept)
//   alu_a/b/cin, alu_s  drive to the slice (a/b/cin zero outside RUN)
//   alu_f, alu_cout     slice outputs, combinational in the same cycle
//   zero                (SERIAL_ALU_ZERO_FLAG_EN only) result == 0 flag

module serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_s,
  input  logic             alu_f,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  input  logic             alu_cout,
  output logic             zero
`else
  input  logic             alu_cout
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [1:0]  OpAdd = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [1:0]        op_q, op_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic              zflag_q, zflag_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zflag_q <= zflag_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    zflag_d = zflag_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
          zflag_d = 1'b1;
`endif
        end
      end
      StRun: begin
        // New bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
        res_d   = {alu_f, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = (op_q == OpAdd) ? alu_cout : 1'b0;
        cnt_d   = cnt_q + CntW'(1);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        zflag_d = zflag_q & ~alu_f;
`endif
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q == StRun);
    done    = (state_q == StDone);
    result  = res_q;
    cout    = carry_q;
    alu_s   = op_q;
    alu_a   = busy ? a_sh_q[0] : 1'b0;
    alu_b   = busy ? b_sh_q[0] : 1'b0;
    alu_cin = busy ? carry_q   : 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    zero    = zflag_q;
`endif
  end

endmodule
